// File: rtl/chart_note_player_pkg.sv
// ============================================================================
// chart_note_player_pkg -- shared chart/note types and player state encoding
// Revision: 1.0
// ============================================================================
`default_nettype none

package chart_note_player_pkg;

    localparam int NOTE_WIDTH = 4;
    localparam int CHART_LEN  = 200;

    typedef logic [NOTE_WIDTH-1:0] Notes;

    localparam Notes NOTE_NU = '0;

    typedef struct packed {
        logic [15:0]            note_cnt;
        Notes [CHART_LEN-1:0]   notes;
    } Chart;

    typedef enum logic [2:0] {
        PL_IDLE,
        PL_LOAD,
        PL_PLAY,
        PL_PAUSED,
        PL_DONE
    } player_state_t;

    // Stored note counts may exceed the physical chart length; never index past it.
    function automatic logic [15:0] clamp_cnt(input logic [15:0] n);
        return (n > 16'(CHART_LEN)) ? 16'(CHART_LEN) : n;
    endfunction

endpackage

`default_nettype wire

// File: rtl/chart_note_player_window.sv
// ============================================================================
// chart_note_window -- current note plus PREVIEW lookahead, NU past eff_cnt
// Revision: 1.0
// ============================================================================
`default_nettype none

module chart_note_window
    import chart_note_player_pkg::*;
#(
    parameter int PREVIEW = 4
) (
    input  Notes [CHART_LEN-1:0] notes_i,
    input  logic [15:0]          idx_i,
    input  logic [15:0]          eff_cnt_i,
    output Notes                 note_o,
    output Notes [PREVIEW-1:0]   window_o
);

    localparam int IDX_W = $clog2(CHART_LEN);

    Notes slot [PREVIEW+1];

    // Slot 0 is the current note, slots 1..PREVIEW the lookahead; no wrap at the end.
    for (genvar k = 0; k <= PREVIEW; k++) begin : g_slot
        localparam logic [16:0] OFFSET = 17'(k);
        logic [16:0] pos;
        assign pos     = {1'b0, idx_i} + OFFSET;
        assign slot[k] = (pos < {1'b0, eff_cnt_i}) ? notes_i[pos[IDX_W-1:0]] : NOTE_NU;
    end

    assign note_o = slot[0];

    for (genvar k = 0; k < PREVIEW; k++) begin : g_win
        assign window_o[k] = slot[k+1];
    end

endmodule

`default_nettype wire

// File: rtl/chart_note_player.sv
// ============================================================================
// chart_note_player -- fetches a chart from storage and steps it per beat_tick
// Revision: 1.0
// ============================================================================
`default_nettype none

module chart_note_player
    import chart_note_player_pkg::*;
#(
    parameter int LOAD_WAIT = 2,
    parameter int PREVIEW   = 4
) (
    input  logic               clk_i,
    input  logic               sys_rst_ni,
    input  logic               start_i,
    input  logic [7:0]         chart_id_i,
    input  logic               pause_i,
    input  logic               abort_i,
    input  logic               beat_tick_i,
    input  Chart               current_chart_data_i,
    output logic [7:0]         read_chart_id_o,
    output Notes               note_out_o,
    output Notes [PREVIEW-1:0] note_window_o,
    output logic [15:0]        note_idx_o,
    output logic               note_valid_o,
    output logic               busy_o,
    output logic               done_o
);

    localparam int                WAIT_W    = $clog2(LOAD_WAIT + 1);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(LOAD_WAIT - 1);

    player_state_t       state_q;
    logic [WAIT_W-1:0]   wait_cnt_q;
    logic [15:0]         eff_cnt_q;
    logic [7:0]          read_chart_id_q;
    Notes                note_out_q;
    Notes [PREVIEW-1:0]  note_window_q;
    logic [15:0]         note_idx_q;
    logic                note_valid_q;
    logic                busy_q;
    logic                done_q;

    logic [15:0]         load_cnt;
    logic [15:0]         win_idx;
    logic [15:0]         win_cnt;
    Notes                win_note;
    Notes [PREVIEW-1:0]  win_window;

    // The window is computed for the index the next edge will present, so the
    // registered outputs update in the same edge that consumes the tick.
    always_comb begin
        load_cnt = clamp_cnt(current_chart_data_i.note_cnt);
        win_idx  = '0;
        win_cnt  = load_cnt;
        if (state_q == PL_PLAY) begin
            win_idx = note_idx_q + 16'd1;
            win_cnt = eff_cnt_q;
        end
    end

    chart_note_window #(
        .PREVIEW   (PREVIEW)
    ) u_window (
        .notes_i   (current_chart_data_i.notes),
        .idx_i     (win_idx),
        .eff_cnt_i (win_cnt),
        .note_o    (win_note),
        .window_o  (win_window)
    );

    always_ff @(posedge clk_i or negedge sys_rst_ni) begin
        if (!sys_rst_ni) begin
            state_q         <= PL_IDLE;
            wait_cnt_q      <= '0;
            eff_cnt_q       <= '0;
            read_chart_id_q <= '0;
            note_out_q      <= NOTE_NU;
            note_window_q   <= {PREVIEW{NOTE_NU}};
            note_idx_q      <= '0;
            note_valid_q    <= 1'b0;
            busy_q          <= 1'b0;
            done_q          <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (abort_i && (state_q == PL_LOAD || state_q == PL_PLAY || state_q == PL_PAUSED)) begin
                state_q         <= PL_IDLE;
                read_chart_id_q <= '0;
                note_out_q      <= NOTE_NU;
                note_window_q   <= {PREVIEW{NOTE_NU}};
                note_idx_q      <= '0;
                note_valid_q    <= 1'b0;
                busy_q          <= 1'b0;
            end else begin
                case (state_q)
                    PL_IDLE: begin
                        if (start_i && chart_id_i != 8'd0) begin
                            state_q         <= PL_LOAD;
                            read_chart_id_q <= chart_id_i;
                            wait_cnt_q      <= '0;
                            busy_q          <= 1'b1;
                        end
                    end
                    PL_LOAD: begin
                        if (wait_cnt_q == WAIT_LAST) begin
                            eff_cnt_q <= load_cnt;
                            if (load_cnt == 16'd0) begin
                                state_q         <= PL_DONE;
                                done_q          <= 1'b1;
                                read_chart_id_q <= '0;
                            end else begin
                                state_q       <= PL_PLAY;
                                note_idx_q    <= '0;
                                note_out_q    <= win_note;
                                note_window_q <= win_window;
                                note_valid_q  <= 1'b1;
                            end
                        end else begin
                            wait_cnt_q <= wait_cnt_q + 1'b1;
                        end
                    end
                    PL_PLAY: begin
                        if (pause_i) begin
                            state_q <= PL_PAUSED;
                        end else if (beat_tick_i) begin
                            if (note_idx_q == eff_cnt_q - 16'd1) begin
                                state_q         <= PL_DONE;
                                done_q          <= 1'b1;
                                read_chart_id_q <= '0;
                                note_out_q      <= NOTE_NU;
                                note_window_q   <= {PREVIEW{NOTE_NU}};
                                note_idx_q      <= '0;
                                note_valid_q    <= 1'b0;
                            end else begin
                                note_idx_q    <= win_idx;
                                note_out_q    <= win_note;
                                note_window_q <= win_window;
                            end
                        end
                    end
                    PL_PAUSED: begin
                        if (!pause_i) begin
                            state_q <= PL_PLAY;
                        end
                    end
                    PL_DONE: begin
                        state_q <= PL_IDLE;
                        busy_q  <= 1'b0;
                    end
                    default: begin
                        state_q <= PL_IDLE;
                        busy_q  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign read_chart_id_o = read_chart_id_q;
    assign note_out_o      = note_out_q;
    assign note_window_o   = note_window_q;
    assign note_idx_o      = note_idx_q;
    assign note_valid_o    = note_valid_q;
    assign busy_o          = busy_q;
    assign done_o          = done_q;

endmodule

`default_nettype wire

// File: tb/tb_chart_note_player.sv
// ============================================================================
// tb_chart_note_player -- randomized self-checking bench with chart-level model
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_chart_note_player;
    import chart_note_player_pkg::*;

    localparam int LOAD_WAIT = 2;
    localparam int PREVIEW   = 4;
    localparam Notes T_C4    = 4'd1;
    localparam Notes T_G4    = 4'd5;

    logic               clk = 1'b0;
    logic               sys_rst_n;
    logic               start, pause, abort, beat_tick;
    logic [7:0]         chart_id;
    Chart               cur_data;
    logic [7:0]         read_chart_id;
    Notes               note_out;
    Notes [PREVIEW-1:0] note_window;
    logic [15:0]        note_idx;
    logic               note_valid, busy, done;

    int n_cmp = 0;
    int n_err = 0;

    Chart mem [1:4];

    always #5 clk = ~clk;

    // Storage model: data for the requested chart is already stable when sampled.
    always_comb begin
        case (read_chart_id)
            8'd1:    cur_data = mem[1];
            8'd2:    cur_data = mem[2];
            8'd3:    cur_data = mem[3];
            8'd4:    cur_data = mem[4];
            default: cur_data = '0;
        endcase
    end

    chart_note_player #(
        .LOAD_WAIT            (LOAD_WAIT),
        .PREVIEW              (PREVIEW)
    ) dut (
        .clk_i                (clk),
        .sys_rst_ni           (sys_rst_n),
        .start_i              (start),
        .chart_id_i           (chart_id),
        .pause_i              (pause),
        .abort_i              (abort),
        .beat_tick_i          (beat_tick),
        .current_chart_data_i (cur_data),
        .read_chart_id_o      (read_chart_id),
        .note_out_o           (note_out),
        .note_window_o        (note_window),
        .note_idx_o           (note_idx),
        .note_valid_o         (note_valid),
        .busy_o               (busy),
        .done_o               (done)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic int eff_of(input int c);
        int n;
        n = int'(mem[c].note_cnt);
        return (n > CHART_LEN) ? CHART_LEN : n;
    endfunction

    function automatic Notes exp_note(input int c, input int i, input int eff);
        return (i < eff) ? mem[c].notes[i] : NOTE_NU;
    endfunction

    task automatic check_view(input int c, input int idx, input int eff);
        chk("idx", 32'(note_idx), 32'(idx));
        chk("note", 32'(note_out), 32'(exp_note(c, idx, eff)));
        for (int k = 0; k < PREVIEW; k++)
            chk($sformatf("win%0d", k), 32'(note_window[k]), 32'(exp_note(c, idx + 1 + k, eff)));
        chk("valid", 32'(note_valid), 32'd1);
        chk("read_held", 32'(read_chart_id), 32'(c));
        if (c == 1 && idx == 0) begin
            chk("ls_note0", 32'(note_out), 32'(NOTE_NU));
            chk("ls_w0", 32'({note_window[0], note_window[1], note_window[2], note_window[3]}),
                32'({NOTE_NU, NOTE_NU, NOTE_NU, T_C4}));
        end
        if (c == 1 && idx == 4)  chk("ls_idx4", 32'(note_out), 32'(T_C4));
        if (c == 1 && idx == 16) chk("ls_idx16", 32'(note_out), 32'(T_G4));
        if (c == 1 && idx == 187)
            chk("ls_tail", 32'({note_window[0], note_window[1], note_window[2], note_window[3]}),
                32'({T_C4, T_C4, NOTE_NU, NOTE_NU}));
    endtask

    task automatic check_idle(input string tag);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_read"}, 32'(read_chart_id), 32'd0);
        chk({tag, "_valid"}, 32'(note_valid), 32'd0);
        chk({tag, "_done"}, 32'(done), 32'd0);
        chk({tag, "_note"}, 32'(note_out), 32'(NOTE_NU));
    endtask

    // Start chart c and walk through the load latency; returns 1 if playing.
    task automatic load_chart(input int c, output bit playing);
        int eff;
        eff      = eff_of(c);
        start    = 1'b1;
        chart_id = 8'(c);
        step();
        start    = 1'b0;
        chk("ld_read", 32'(read_chart_id), 32'(c));
        chk("ld_busy", 32'(busy), 32'd1);
        chk("ld_valid", 32'(note_valid), 32'd0);
        beat_tick = 1'b1;
        for (int w = 1; w < LOAD_WAIT; w++) begin
            step();
            chk("ld_wait_valid", 32'(note_valid), 32'd0);
        end
        step();
        beat_tick = 1'b0;
        playing = (eff != 0);
        if (eff == 0) begin
            chk("empty_done", 32'(done), 32'd1);
            chk("empty_valid", 32'(note_valid), 32'd0);
            step();
            chk("empty_done_clr", 32'(done), 32'd0);
            chk("empty_busy", 32'(busy), 32'd0);
        end else begin
            check_view(c, 0, eff);
        end
    endtask

    // Model: a tick advances only when pause is low at this edge and was low at
    // the previous edge of play (a released pause costs one cycle, no advance).
    task automatic run_play(input int c, input int tick_pct, input int pause_pct, input int abort_at);
        int eff, cnt;
        bit playing, pz, pprev, tk, finished;
        eff = eff_of(c);
        load_chart(c, playing);
        if (!playing) return;
        cnt = 0; pz = 0; pprev = 0; finished = 0;
        for (int b = 0; b < 3000 && !finished; b++) begin
            tk = ($urandom % 100) < tick_pct;
            if (($urandom % 100) < pause_pct) pz = !pz;
            if (cnt == abort_at) begin
                abort = 1'b1; beat_tick = 1'b1; pause = pz;
                step();
                abort = 1'b0; beat_tick = 1'b0; pause = 1'b0;
                check_idle("abort");
                step();
                chk("abort_no_done", 32'(done), 32'd0);
                return;
            end
            beat_tick = tk;
            pause     = pz;
            step();
            if (tk && !pz && !pprev) cnt++;
            pprev = pz;
            if (cnt == eff) begin
                beat_tick = 1'b0; pause = 1'b0;
                chk("done_pulse", 32'(done), 32'd1);
                chk("done_valid", 32'(note_valid), 32'd0);
                chk("done_note", 32'(note_out), 32'(NOTE_NU));
                chk("done_read", 32'(read_chart_id), 32'd0);
                chk("done_busy", 32'(busy), 32'd1);
                step();
                check_idle("after_done");
                finished = 1;
            end else begin
                check_view(c, cnt, eff);
            end
        end
        beat_tick = 1'b0;
        pause     = 1'b0;
        if (!finished) chk("play_timeout", 32'd0, 32'd1);
    endtask

    task automatic fill_chart(input int c, input int cnt);
        mem[c].note_cnt = 16'(cnt);
        for (int i = 0; i < CHART_LEN; i++) mem[c].notes[i] = Notes'($urandom_range(0, 8));
    endtask

    initial begin
        bit playing;
        sys_rst_n = 1'b0;
        start = 0; pause = 0; abort = 0; beat_tick = 0; chart_id = 0;

        fill_chart(1, 190);
        for (int i = 0; i < 4; i++) mem[1].notes[i] = NOTE_NU;
        mem[1].notes[4]   = T_C4;
        mem[1].notes[16]  = T_G4;
        mem[1].notes[188] = T_C4;
        mem[1].notes[189] = T_C4;
        fill_chart(2, 0);
        fill_chart(3, 300);
        fill_chart(4, 5);

        repeat (2) @(posedge clk);
        #1;
        check_idle("reset");
        chk("reset_idx", 32'(note_idx), 32'd0);
        chk("reset_win", 32'(note_window), 32'd0);
        @(negedge clk);
        sys_rst_n = 1'b1;
        step();

        // chart_id 0 is not a chart
        start = 1'b1; chart_id = 8'd0;
        step();
        start = 1'b0;
        repeat (3) begin
            check_idle("id0");
            step();
        end

        // Full play of Little Stars, one tick per cycle
        run_play(1, 100, 0, -1);

        // Pause with a coincident tick, ticks while paused, then resume
        load_chart(1, playing);
        beat_tick = 1'b1;
        repeat (10) step();
        chk("pz_pre", 32'(note_idx), 32'd10);
        pause = 1'b1;
        step();
        chk("pz_hold", 32'(note_idx), 32'd10);
        repeat (5) step();
        chk("pz_ticks", 32'(note_idx), 32'd10);
        start = 1'b1; chart_id = 8'd3;
        beat_tick = 1'b0; pause = 1'b0;
        step();
        start = 1'b0;
        chk("pz_resume", 32'(note_idx), 32'd10);
        chk("pz_start_ign", 32'(read_chart_id), 32'd1);
        beat_tick = 1'b1;
        step();
        beat_tick = 1'b0;
        chk("pz_next", 32'(note_idx), 32'd11);
        check_view(1, 11, 190);
        abort = 1'b1;
        step();
        abort = 1'b0;
        check_idle("pz_abort");

        // Abort during load
        start = 1'b1; chart_id = 8'd1;
        step();
        start = 1'b0; abort = 1'b1;
        step();
        abort = 1'b0;
        check_idle("ld_abort");
        step();
        check_idle("ld_abort2");

        // Abort mid-play at idx 50
        run_play(1, 100, 0, 50);

        // Asynchronous reset mid-play
        load_chart(1, playing);
        beat_tick = 1'b1;
        repeat (7) step();
        beat_tick = 1'b0;
        #2 sys_rst_n = 1'b0;
        #1;
        check_idle("arst");
        chk("arst_idx", 32'(note_idx), 32'd0);
        chk("arst_win", 32'(note_window), 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        sys_rst_n = 1'b1;
        step();
        check_idle("arst_after");

        // Empty chart and oversized note_cnt
        run_play(2, 100, 0, -1);
        run_play(3, 100, 0, -1);

        // Randomized charts, tick/pause patterns and aborts
        for (int t = 0; t < 24; t++) begin
            fill_chart(4, int'($urandom_range(0, 12)));
            run_play(4, 60, 15, (($urandom % 4) == 0) ? int'($urandom_range(0, 5)) : -1);
            repeat (int'($urandom_range(0, 2))) step();
        end

        // Long random play with pauses on the stored chart
        run_play(1, 70, 10, -1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule

`default_nettype wire
